// File: rtl/greenflow_pkg.sv
// -----------------------------------------------------------------------------
// greenflow_pkg
//
// Shared definitions for the multi-channel GreenFlow safety gate:
//   - per-channel status codes driven on status_code
//   - per-channel FSM state encoding (RUN / TRIP / LOST)
//   - statusFor(): maps a channel's next state plus its clamp flag to a status
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package greenflow_pkg;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_CLAMP  = 2'b01;
  localparam logic [1:0] ST_THERM  = 2'b10;
  localparam logic [1:0] ST_AILOST = 2'b11;

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_TRIP = 2'b01,
    S_LOST = 2'b10
  } chanState_e;

  // A running channel reports "clamped" whenever it was granted less than it
  // asked for; any non-running channel reports the reason it is not running.
  function automatic logic [1:0] statusFor(chanState_e state, logic clamped);
    logic [1:0] code;
    case (state)
      S_RUN:   code = clamped ? ST_CLAMP : ST_OK;
      S_TRIP:  code = ST_THERM;
      default: code = ST_AILOST;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/greenflow_chan.sv
// -----------------------------------------------------------------------------
// greenflow_chan
//
// One charger channel of the GreenFlow gate: owns the RUN/TRIP/LOST FSM, the
// AI watchdog, the thermal hysteresis and the output (ramp) register. The
// budget allocation lives in the parent; this block hands up its clamped
// request and receives back its grant in the same cycle.
//
// Configuration macro: GREENFLOW_RAMP_EN
//   defined   -> upward output steps limited to RAMP_STEP per cycle
//   undefined -> output follows the grant directly (RAMP_STEP unused)
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   valid_i        AI request valid for this channel
//   req_i          requested power (kW)
//   temp_i         battery temperature (degC)
//   limit_i        per-channel hard power limit
//   tempLimit_i    shared trip temperature
//   grant_i        budget-limited grant from the parent allocation chain
//   clampReq_o     request after state gating and hard-limit clamp
//   outNext_o      next value of the output register (feeds the total adder)
//   faultNext_o    next state is TRIP or LOST
//   out_o          registered power command
//   status_o       registered status code
// -----------------------------------------------------------------------------
module greenflow_chan
  import greenflow_pkg::*;
#(
  parameter int unsigned W           = 16,
  parameter int unsigned RAMP_STEP   = 16,
  parameter int unsigned WDOG_CYCLES = 1000,
  parameter int unsigned HYST        = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] req_i,
  input  logic [W-1:0] temp_i,
  input  logic [W-1:0] limit_i,
  input  logic [W-1:0] tempLimit_i,
  input  logic [W-1:0] grant_i,
  output logic [W-1:0] clampReq_o,
  output logic [W-1:0] outNext_o,
  output logic         faultNext_o,
  output logic [W-1:0] out_o,
  output logic [1:0]   status_o
);

  localparam int unsigned CW = $clog2(WDOG_CYCLES + 1);
  localparam logic [CW-1:0] WdogMax = CW'(WDOG_CYCLES);
  localparam logic [W-1:0]  HystW   = W'(HYST);
`ifdef GREENFLOW_RAMP_EN
  localparam bit RampEn = 1'b1;
`else
  localparam bit RampEn = 1'b0;
`endif

  chanState_e    state_q, state_d;
  logic [CW-1:0] wdogCnt_q, wdogCnt_d;
  logic [W-1:0]  out_q, out_d;
  logic [1:0]    status_q, status_d;

  logic          wdogExpired;
  logic          tempHot;
  logic          tempCool;
  logic [W-1:0]  releaseTemp;
  logic [W:0]    rampCeil;

  // Watchdog: counts cycles since the last valid request and parks at the
  // limit. Expiry is judged on the next count so that the LOST status shows up
  // on the same edge the counter reaches the limit.
  always_comb begin
    wdogCnt_d = wdogCnt_q;
    if (valid_i) begin
      wdogCnt_d = '0;
    end else if (wdogCnt_q != WdogMax) begin
      wdogCnt_d = wdogCnt_q + CW'(1);
    end
    wdogExpired = (wdogCnt_d == WdogMax);
  end

  // Thermal thresholds: trip strictly above the limit, release only once the
  // temperature has fallen HYST below it. The release point floors at zero so
  // a small limit cannot wrap into a huge threshold.
  always_comb begin
    tempHot     = (temp_i > tempLimit_i);
    releaseTemp = (tempLimit_i > HystW) ? (tempLimit_i - HystW) : '0;
    tempCool    = (temp_i <= releaseTemp);
  end

  // Next-state logic. A thermal trip overrides everything; a channel leaving
  // TRIP with a dead watchdog goes to LOST rather than back to RUN.
  always_comb begin
    state_d = state_q;
    if (tempHot) begin
      state_d = S_TRIP;
    end else begin
      case (state_q)
        S_RUN:   if (wdogExpired) state_d = S_LOST;
        S_TRIP:  if (tempCool)    state_d = wdogExpired ? S_LOST : S_RUN;
        S_LOST:  if (valid_i)     state_d = S_RUN;
        default: state_d = S_LOST;
      endcase
    end
  end

  // Request offered to the budget chain: nothing unless the channel will be
  // running next cycle, otherwise the request capped at the hard limit. Kept
  // free of any grant dependence so the parent chain stays acyclic.
  always_comb begin
    clampReq_o = '0;
    if (state_d == S_RUN) begin
      clampReq_o = (req_i < limit_i) ? req_i : limit_i;
    end
  end

  // Output shaping. Decreases (including the drop to zero on a fault) take
  // effect at once; increases are limited to RAMP_STEP when ramping is built
  // in. The ceiling is one bit wider so out_q + RAMP_STEP cannot wrap.
  always_comb begin
    rampCeil = {1'b0, out_q} + (W+1)'(RAMP_STEP);
    out_d    = grant_i;
    if (RampEn && (grant_i > out_q) && (rampCeil < {1'b0, grant_i})) begin
      out_d = rampCeil[W-1:0];
    end
    status_d    = statusFor(state_d, (grant_i < req_i));
    faultNext_o = (state_d != S_RUN);
    outNext_o   = out_d;
  end

  // State, watchdog and output registers. Reset parks the channel in LOST
  // with zero output so it must see a valid request before delivering power.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_LOST;
      wdogCnt_q <= '0;
      out_q     <= '0;
      status_q  <= ST_AILOST;
    end else begin
      state_q   <= state_d;
      wdogCnt_q <= wdogCnt_d;
      out_q     <= out_d;
      status_q  <= status_d;
    end
  end

  assign out_o    = out_q;
  assign status_o = status_q;

endmodule

// File: rtl/greenflow_gate_mc.sv
// -----------------------------------------------------------------------------
// greenflow_gate_mc
//
// Multi-channel GreenFlow safety gate between the AI power planner and the
// charger power stages. Each channel (greenflow_chan) gates, clamps and ramps
// its own command; this level shares the total grid budget among channels in
// fixed priority order (channel 0 first) and sums the delivered power.
//
// Configuration macro: GREENFLOW_RAMP_EN (see greenflow_chan).
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   ai_data_valid       per-channel request valid (bit i = channel i)
//   llm_requested_kw    per-channel request, channel i at [i*W +: W]
//   battery_temp_c      per-channel battery temperature
//   grid_limit_hard     per-channel hard power limit
//   grid_budget_total   shared budget across all channels
//   temp_limit_hard     shared trip temperature
//   safe_power_out      registered per-channel power command
//   status_code         registered per-channel status, 2 bits each
//   any_fault           registered OR of channels in TRIP or LOST
//   total_power_out     registered sum of safe_power_out
// -----------------------------------------------------------------------------
module greenflow_gate_mc
  import greenflow_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned W           = 16,
  parameter int unsigned RAMP_STEP   = 16,
  parameter int unsigned WDOG_CYCLES = 1000,
  parameter int unsigned HYST        = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CH-1:0]               ai_data_valid,
  input  logic [N_CH*W-1:0]             llm_requested_kw,
  input  logic [N_CH*W-1:0]             battery_temp_c,
  input  logic [N_CH*W-1:0]             grid_limit_hard,
  input  logic [W-1:0]                  grid_budget_total,
  input  logic [W-1:0]                  temp_limit_hard,
  output logic [N_CH*W-1:0]             safe_power_out,
  output logic [N_CH*2-1:0]             status_code,
  output logic                          any_fault,
  output logic [W+$clog2(N_CH)-1:0]     total_power_out
);

  localparam int unsigned TW = W + $clog2(N_CH);

  logic [W-1:0]    clampReq [N_CH];
  logic [W-1:0]    grant    [N_CH];
  logic [W-1:0]    outNext  [N_CH];
  logic [N_CH-1:0] faultNext;
  logic [TW-1:0]   totalNext;
  logic [TW-1:0]   total_q;
  logic            anyFault_q;

  for (genvar c = 0; c < N_CH; c++) begin : gChan
    greenflow_chan #(
      .W           (W),
      .RAMP_STEP   (RAMP_STEP),
      .WDOG_CYCLES (WDOG_CYCLES),
      .HYST        (HYST)
    ) uChan (
      .clk         (clk),
      .rst         (rst),
      .valid_i     (ai_data_valid[c]),
      .req_i       (llm_requested_kw[c*W +: W]),
      .temp_i      (battery_temp_c[c*W +: W]),
      .limit_i     (grid_limit_hard[c*W +: W]),
      .tempLimit_i (temp_limit_hard),
      .grant_i     (grant[c]),
      .clampReq_o  (clampReq[c]),
      .outNext_o   (outNext[c]),
      .faultNext_o (faultNext[c]),
      .out_o       (safe_power_out[c*W +: W]),
      .status_o    (status_code[c*2 +: 2])
    );
  end

  // Budget allocation chain: each channel takes what it asks for out of what
  // the lower-numbered channels left behind, so the grants can never sum to
  // more than the shared budget.
  always_comb begin
    logic [W-1:0] remaining;
    remaining = grid_budget_total;
    for (int i = 0; i < N_CH; i++) begin
      grant[i]  = (clampReq[i] < remaining) ? clampReq[i] : remaining;
      remaining = remaining - grant[i];
    end
  end

  // Total adder over the next output values, so the registered total lines
  // up with the registered per-channel outputs.
  always_comb begin
    totalNext = '0;
    for (int i = 0; i < N_CH; i++) begin
      totalNext = totalNext + TW'(outNext[i]);
    end
  end

  // Summary registers. Reset reports a fault because every channel starts in
  // LOST.
  always_ff @(posedge clk) begin
    if (rst) begin
      anyFault_q <= 1'b1;
      total_q    <= '0;
    end else begin
      anyFault_q <= |faultNext;
      total_q    <= totalNext;
    end
  end

  assign any_fault       = anyFault_q;
  assign total_power_out = total_q;

endmodule

// File: tb/tb_greenflow_gate_mc.sv
// -----------------------------------------------------------------------------
// tb_greenflow_gate_mc
//
// Self-checking bench for greenflow_gate_mc (N_CH=2, W=16, RAMP_STEP=50,
// WDOG_CYCLES=8, HYST=5). A directed sequence walks through ramp-up, clamping,
// thermal trip/release, watchdog loss, coincident trip+loss and mid-run reset,
// then a randomized phase exercises the same rules. Every cycle the outputs
// are compared against a behavioural model of the gate's rules.
// Follows GREENFLOW_RAMP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_greenflow_gate_mc;

  localparam int N_CH      = 2;
  localparam int W         = 16;
  localparam int RAMP_STEP = 50;
  localparam int WDOG      = 8;
  localparam int HYST      = 5;
  localparam int TW        = W + $clog2(N_CH);
  localparam int M_RUN     = 0;
  localparam int M_TRIP    = 1;
  localparam int M_LOST    = 2;
`ifdef GREENFLOW_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [N_CH-1:0]   ai_data_valid;
  logic [N_CH*W-1:0] llm_requested_kw;
  logic [N_CH*W-1:0] battery_temp_c;
  logic [N_CH*W-1:0] grid_limit_hard;
  logic [W-1:0]      grid_budget_total;
  logic [W-1:0]      temp_limit_hard;
  logic [N_CH*W-1:0] safe_power_out;
  logic [N_CH*2-1:0] status_code;
  logic              any_fault;
  logic [TW-1:0]     total_power_out;

  greenflow_gate_mc #(
    .N_CH        (N_CH),
    .W           (W),
    .RAMP_STEP   (RAMP_STEP),
    .WDOG_CYCLES (WDOG),
    .HYST        (HYST)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ai_data_valid     (ai_data_valid),
    .llm_requested_kw  (llm_requested_kw),
    .battery_temp_c    (battery_temp_c),
    .grid_limit_hard   (grid_limit_hard),
    .grid_budget_total (grid_budget_total),
    .temp_limit_hard   (temp_limit_hard),
    .safe_power_out    (safe_power_out),
    .status_code       (status_code),
    .any_fault         (any_fault),
    .total_power_out   (total_power_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit validV [N_CH];
  int reqV   [N_CH];
  int tempV  [N_CH];
  int limV   [N_CH];
  int budgetV;
  int tlimV;
  bit rstV;

  int mState  [N_CH];
  int mIdle   [N_CH];
  int mOut    [N_CH];
  int mStatus [N_CH];
  int mTotal;
  int mFault;

  int checks;
  int errors;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference model of the gate rules for one clock edge, in plain integers.
  task automatic stepModel();
    int rem, rq, g, rel, nxt;
    bit hot, expired;
    if (rstV) begin
      for (int c = 0; c < N_CH; c++) begin
        mState[c] = M_LOST; mIdle[c] = 0; mOut[c] = 0; mStatus[c] = 3;
      end
      mTotal = 0;
      mFault = 1;
      return;
    end
    rem    = budgetV;
    mTotal = 0;
    mFault = 0;
    rel    = (tlimV > HYST) ? tlimV - HYST : 0;
    for (int c = 0; c < N_CH; c++) begin
      mIdle[c] = validV[c] ? 0 : ((mIdle[c] < WDOG) ? mIdle[c] + 1 : WDOG);
      expired  = (mIdle[c] >= WDOG);
      hot      = (tempV[c] > tlimV);
      nxt      = mState[c];
      if (hot) nxt = M_TRIP;
      else if (mState[c] == M_RUN) nxt = expired ? M_LOST : M_RUN;
      else if (mState[c] == M_TRIP) begin
        if (tempV[c] <= rel) nxt = expired ? M_LOST : M_RUN;
      end else if (validV[c]) nxt = M_RUN;
      mState[c] = nxt;
      rq  = (nxt == M_RUN) ? ((reqV[c] < limV[c]) ? reqV[c] : limV[c]) : 0;
      g   = (rq < rem) ? rq : rem;
      rem = rem - g;
      if (RAMP_ON && g > mOut[c]) mOut[c] = (mOut[c] + RAMP_STEP < g) ? mOut[c] + RAMP_STEP : g;
      else mOut[c] = g;
      if (nxt == M_RUN) mStatus[c] = (g < reqV[c]) ? 1 : 0;
      else mStatus[c] = (nxt == M_TRIP) ? 2 : 3;
      mTotal = mTotal + mOut[c];
      if (nxt != M_RUN) mFault = 1;
    end
  endtask

  task automatic compareAll();
    for (int c = 0; c < N_CH; c++) begin
      checkOutput($sformatf("out%0d", c), int'(safe_power_out[c*W +: W]), mOut[c]);
      checkOutput($sformatf("status%0d", c), int'(status_code[c*2 +: 2]), mStatus[c]);
    end
    checkOutput("total", int'(total_power_out), mTotal);
    checkOutput("any_fault", int'(any_fault), mFault);
  endtask

  // Holds the current stimulus for a number of cycles: drive at the falling
  // edge, advance the model, then compare just after the rising edge.
  task automatic applyStimulus(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      rst               = rstV;
      grid_budget_total = W'(budgetV);
      temp_limit_hard   = W'(tlimV);
      for (int c = 0; c < N_CH; c++) begin
        ai_data_valid[c]            = validV[c];
        llm_requested_kw[c*W +: W]  = W'(reqV[c]);
        battery_temp_c[c*W +: W]    = W'(tempV[c]);
        grid_limit_hard[c*W +: W]   = W'(limV[c]);
      end
      stepModel();
      @(posedge clk);
      #1;
      compareAll();
      @(negedge clk);
    end
  endtask

  task automatic setCommon();
    for (int c = 0; c < N_CH; c++) begin
      validV[c] = 1'b1; tempV[c] = 25; limV[c] = 200;
    end
    reqV[0] = 150; reqV[1] = 100;
    budgetV = 300; tlimV = 45; rstV = 1'b0;
  endtask

  bit silent [N_CH];

  initial begin
    checks = 0;
    errors = 0;
    setCommon();
    rstV = 1'b1;
    @(negedge clk);
    applyStimulus(2);
    checkOutput("rst_total", int'(total_power_out), 0);
    checkOutput("rst_fault", int'(any_fault), 1);
    checkOutput("rst_status", int'(status_code), 4'b1111);

    $display("[TB] ramp-up");
    rstV = 1'b0;
    applyStimulus(4);

    $display("[TB] clamp and budget");
    reqV[0] = 300; applyStimulus(4);
    reqV[1] = 150; applyStimulus(3);

    $display("[TB] thermal trip with hysteresis");
    tempV[0] = 50; applyStimulus(3);
    tempV[0] = 42; applyStimulus(3);
    tempV[0] = 40; applyStimulus(4);

    $display("[TB] watchdog");
    validV[1] = 1'b0; applyStimulus(10);
    validV[1] = 1'b1; applyStimulus(1);
    validV[1] = 1'b0; applyStimulus(4);
    validV[1] = 1'b1; applyStimulus(3);

    $display("[TB] coincident trip and watchdog expiry");
    validV[0] = 1'b0; applyStimulus(WDOG - 1);
    tempV[0] = 50; applyStimulus(1);
    tempV[0] = 30; applyStimulus(3);
    validV[0] = 1'b1; applyStimulus(4);

    $display("[TB] mid-operation reset");
    setCommon(); reqV[0] = 300; reqV[1] = 150; applyStimulus(3);
    rstV = 1'b1; applyStimulus(1);
    checkOutput("midrst_total", int'(total_power_out), 0);
    rstV = 1'b0; applyStimulus(4);

    $display("[TB] randomized phase");
    for (int k = 0; k < 600; k++) begin
      rstV = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 9) == 0) budgetV = $urandom_range(0, 600);
      if ($urandom_range(0, 19) == 0)
        tlimV = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : $urandom_range(35, 50);
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 19) == 0) silent[c] = !silent[c];
        validV[c] = silent[c] ? 1'b0 : ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) reqV[c] = $urandom_range(0, 400);
        if ($urandom_range(0, 7) == 0) tempV[c] = $urandom_range(0, 60);
        if ($urandom_range(0, 15) == 0) limV[c] = $urandom_range(0, 300);
      end
      applyStimulus(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
